// File: rtl/ll_fifo_pkg.sv
// ll_fifo_pkg
//   Shared definitions for the LocalLink frame FIFO.
//   - wr_state_e : write-side frame filter states
//   - *_BIT      : flag positions inside a storage entry, counted from the
//                  first bit above the data field (entry = {flags, data})
package ll_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      DISCARD  = 2'd2
   } wr_state_e;

   localparam int SOF_BIT = 0;
   localparam int EOF_BIT = 1;
   localparam int ERR_BIT = 2;
   localparam int FLAG_W  = 3;

endpackage

// File: rtl/ll_fifo_ram.sv
// ll_fifo_ram
//   Simple dual-port RAM: synchronous write, asynchronous read.
//   Ports:
//     clk   in  clock
//     we    in  write enable
//     waddr in  write address (AW bits)
//     wdata in  write data (W bits)
//     raddr in  read address (AW bits)
//     rdata out read data, combinational from raddr
module ll_fifo_ram #(
   parameter int W  = 11,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ll_pkt_fifo.sv
// ll_pkt_fifo
//   LocalLink frame FIFO with optional store-and-forward filtering.
//   PKT_MODE=1 releases only complete, error-free frames; errored, headless
//   or oversize frames are dropped. PKT_MODE=0 is a plain cut-through FIFO.
//   Ports:
//     clk, reset(async, active-low), clear(sync)
//     write side : datain, sof_i, eof_i, error_i, src_rdy_i -> dst_rdy_o
//     read side  : dataout, sof_o, eof_o, error_o, src_rdy_o <- dst_rdy_i
//     status     : occupied, space, pkt_count, dropped, oversize
//     dbg_state  : current write-filter state
//   Handshake: a word moves on a side in any cycle where that side's
//   src_rdy and dst_rdy are both high at the rising clock edge; a source
//   holds its word stable until it moves, and ready never waits on valid.
module ll_pkt_fifo
   import ll_fifo_pkg::*;
#(
   parameter int DW       = 8,
   parameter int AW       = 4,
   parameter bit PKT_MODE = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic [DW-1:0] datain,
   input  logic          sof_i,
   input  logic          eof_i,
   input  logic          error_i,
   input  logic          src_rdy_i,
   output logic          dst_rdy_o,
   output logic [DW-1:0] dataout,
   output logic          sof_o,
   output logic          eof_o,
   output logic          error_o,
   output logic          src_rdy_o,
   input  logic          dst_rdy_i,
   output logic [AW:0]   occupied,
   output logic [AW:0]   space,
   output logic [AW:0]   pkt_count,
   output logic          dropped,
   output logic          oversize,
   output wr_state_e     dbg_state
);

   localparam int          EW      = DW + FLAG_W;
   localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   wr_state_e   state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] wr_commit_q, wr_commit_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] pkt_count_q, pkt_count_d;
   logic        dropped_q, dropped_d;
   logic        oversize_q, oversize_d;

   logic [AW:0]   fill;
   logic          full, empty, wr_fire, rd_fire, eof_rd, commit;
   logic          ram_we;
   logic [AW-1:0] wr_addr;
   logic [EW-1:0] wdata, rd_entry;

   assign fill      = wr_ptr_q - rd_ptr_q;
   assign full      = (fill == DEPTH);
   assign empty     = (rd_ptr_q == wr_commit_q);
   assign dst_rdy_o = (state_q == DISCARD) | ~full;
   assign src_rdy_o = ~empty;
   assign wr_fire   = src_rdy_i & dst_rdy_o;
   assign rd_fire   = src_rdy_o & dst_rdy_i;
   assign eof_rd    = rd_fire & rd_entry[DW+EOF_BIT];

   // In packet mode no errored word is ever stored, so error_o stays 0.
   always_comb begin
      wdata                = '0;
      wdata[DW-1:0]        = datain;
      wdata[DW+SOF_BIT]    = sof_i;
      wdata[DW+EOF_BIT]    = eof_i;
      wdata[DW+ERR_BIT]    = PKT_MODE ? 1'b0 : error_i;
   end

   ll_fifo_ram #(.W(EW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (wdata),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (rd_entry)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      rd_ptr_d    = rd_fire ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      dropped_d   = 1'b0;
      oversize_d  = 1'b0;
      ram_we      = 1'b0;
      wr_addr     = wr_ptr_q[AW-1:0];
      commit      = 1'b0;

      if (!PKT_MODE) begin
         if (wr_fire) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            commit   = eof_i;
         end
         wr_commit_d = wr_ptr_d;
      end else begin
         unique case (state_q)
            IDLE, IN_FRAME: begin
               if (state_q == IN_FRAME && full && wr_commit_q == rd_ptr_q) begin
                  // The partial frame fills the whole FIFO and can never
                  // complete: throw it away and swallow the rest of it.
                  wr_ptr_d   = wr_commit_q;
                  oversize_d = 1'b1;
                  state_d    = DISCARD;
               end else if (wr_fire) begin
                  if (sof_i) begin
                     // A new frame always starts at the commit point; in
                     // IDLE wr_ptr already equals wr_commit, in IN_FRAME
                     // this abandons the unfinished frame.
                     wr_addr   = wr_commit_q[AW-1:0];
                     dropped_d = (state_q == IN_FRAME) | (eof_i & error_i);
                     if (eof_i & error_i) begin
                        wr_ptr_d = wr_commit_q;
                        state_d  = IDLE;
                     end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_commit_q + PTR_ONE;
                        if (eof_i) begin
                           wr_commit_d = wr_commit_q + PTR_ONE;
                           commit      = 1'b1;
                           state_d     = IDLE;
                        end else begin
                           state_d = IN_FRAME;
                        end
                     end
                  end else if (state_q == IDLE) begin
                     dropped_d = 1'b1;
                  end else if (eof_i & error_i) begin
                     wr_ptr_d  = wr_commit_q;
                     dropped_d = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PTR_ONE;
                     if (eof_i) begin
                        wr_commit_d = wr_ptr_q + PTR_ONE;
                        commit      = 1'b1;
                        state_d     = IDLE;
                     end
                  end
               end
            end
            DISCARD: begin
               if (wr_fire && eof_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      unique case ({commit, eof_rd})
         2'b10:   pkt_count_d = pkt_count_q + PTR_ONE;
         2'b01:   pkt_count_d = pkt_count_q - PTR_ONE;
         default: pkt_count_d = pkt_count_q;
      endcase

      if (clear) begin
         state_d     = IDLE;
         wr_ptr_d    = '0;
         wr_commit_d = '0;
         rd_ptr_d    = '0;
         pkt_count_d = '0;
         dropped_d   = 1'b0;
         oversize_d  = 1'b0;
         ram_we      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         pkt_count_q <= '0;
         dropped_q   <= 1'b0;
         oversize_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         pkt_count_q <= pkt_count_d;
         dropped_q   <= dropped_d;
         oversize_q  <= oversize_d;
      end
   end

   assign dataout   = src_rdy_o ? rd_entry[DW-1:0] : '0;
   assign sof_o     = src_rdy_o & rd_entry[DW+SOF_BIT];
   assign eof_o     = src_rdy_o & rd_entry[DW+EOF_BIT];
   assign error_o   = src_rdy_o & rd_entry[DW+ERR_BIT];
   assign occupied  = fill;
   assign space     = DEPTH - fill;
   assign pkt_count = pkt_count_q;
   assign dropped   = dropped_q;
   assign oversize  = oversize_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ll_pkt_fifo.sv
// tb_ll_pkt_fifo
//   Bench for ll_pkt_fifo: one packet-mode instance driven through the
//   frame scenarios with a read-side scoreboard, plus one cut-through
//   instance for the pass-through case. Inputs change 1 time unit after a
//   rising edge; outputs are sampled on the falling edge.
module tb_ll_pkt_fifo;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clear = 1'b0;

   // packet-mode instance
   logic [DW-1:0] datain = '0;
   logic          sof_i = 0, eof_i = 0, error_i = 0, src_rdy_i = 0, dst_rdy_i = 0;
   logic          dst_rdy_o, sof_o, eof_o, error_o, src_rdy_o, dropped, oversize;
   logic [DW-1:0] dataout;
   logic [AW:0]   occupied, space, pkt_count;
   logic [1:0]    dbg_state;

   // cut-through instance
   logic [DW-1:0] c_datain = '0;
   logic          c_sof_i = 0, c_eof_i = 0, c_error_i = 0, c_src_rdy_i = 0, c_dst_rdy_i = 0;
   logic          c_dst_rdy_o, c_sof_o, c_eof_o, c_error_o, c_src_rdy_o, c_dropped, c_oversize;
   logic [DW-1:0] c_dataout;
   logic [AW:0]   c_occupied, c_space, c_pkt_count;
   logic [1:0]    c_dbg_state;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int drop_cnt  = 0;
   int ovs_cnt   = 0;
   int c_drop_cnt = 0;
   logic        seen_rdy = 1'b0;
   logic [AW:0] occ_at_ovs = '0;

   // entry = {sof, eof, data}
   logic [DW+1:0] exp_q[$];

   ll_pkt_fifo #(.DW(DW), .AW(AW), .PKT_MODE(1'b1)) u_dut_pkt (
      .clk(clk), .reset(reset), .clear(clear),
      .datain(datain), .sof_i(sof_i), .eof_i(eof_i), .error_i(error_i),
      .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
      .dataout(dataout), .sof_o(sof_o), .eof_o(eof_o), .error_o(error_o),
      .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
      .occupied(occupied), .space(space), .pkt_count(pkt_count),
      .dropped(dropped), .oversize(oversize), .dbg_state(dbg_state)
   );

   ll_pkt_fifo #(.DW(DW), .AW(AW), .PKT_MODE(1'b0)) u_dut_ct (
      .clk(clk), .reset(reset), .clear(clear),
      .datain(c_datain), .sof_i(c_sof_i), .eof_i(c_eof_i), .error_i(c_error_i),
      .src_rdy_i(c_src_rdy_i), .dst_rdy_o(c_dst_rdy_o),
      .dataout(c_dataout), .sof_o(c_sof_o), .eof_o(c_eof_o), .error_o(c_error_o),
      .src_rdy_o(c_src_rdy_o), .dst_rdy_i(c_dst_rdy_i),
      .occupied(c_occupied), .space(c_space), .pkt_count(c_pkt_count),
      .dropped(c_dropped), .oversize(c_oversize), .dbg_state(c_dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // read-side monitor and pulse counters
   always @(negedge clk) begin
      if (dropped)   drop_cnt++;
      if (c_dropped) c_drop_cnt++;
      if (oversize) begin
         ovs_cnt++;
         occ_at_ovs = occupied;
      end
      if (src_rdy_o) seen_rdy = 1'b1;
      if (src_rdy_o && dst_rdy_i) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_word", 32'(dataout), 32'hFFFF_FFFF);
         end else begin
            logic [DW+1:0] e;
            e = exp_q.pop_front();
            check_val("rd_word", 32'({error_o, sof_o, eof_o, dataout}), 32'({1'b0, e}));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_word(input logic s, input logic e, input logic er, input logic [DW-1:0] d);
      logic acc;
      datain = d; sof_i = s; eof_i = e; error_i = er; src_rdy_i = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk);
         acc = dst_rdy_o;
         @(posedge clk);
         #1;
      end
      if (!acc) check_val("send_timeout", 32'(acc), 32'd1);
   endtask

   task automatic send_frame(input int len, input logic [DW-1:0] base, input logic err_last,
                             input logic push);
      for (int i = 0; i < len; i++) begin
         logic s, e;
         logic [DW-1:0] d;
         s = (i == 0);
         e = (i == len - 1);
         d = base + DW'(i);
         if (push) exp_q.push_back({s, e, d});
         send_word(s, e, err_last & e, d);
      end
      src_rdy_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      logic done;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !src_rdy_o) done = 1'b1;
      end
      check_val("drain_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_dst_rdy"},  32'(dst_rdy_o), 32'd1);
      check_val({tag, "_src_rdy"},  32'(src_rdy_o), 32'd0);
      check_val({tag, "_data"},     32'({sof_o, eof_o, error_o, dataout}), 32'd0);
      check_val({tag, "_occupied"}, 32'(occupied), 32'd0);
      check_val({tag, "_space"},    32'(space), 32'd16);
      check_val({tag, "_pkt_cnt"},  32'(pkt_count), 32'd0);
      check_val({tag, "_pulses"},   32'({dropped, oversize}), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   int drop0, ovs0;

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("rst");
      check_val("rst_ct_rdy", 32'({c_dst_rdy_o, c_src_rdy_o}), 32'b10);
      @(posedge clk);
      #1 reset = 1'b1;
      idle(2);

      // 1: 10-byte good frame, consumer always ready
      dst_rdy_i = 1'b1;
      seen_rdy  = 1'b0;
      send_frame(10, 8'h01, 1'b0, 1'b1);
      check_val("t1_no_early", 32'(seen_rdy), 32'd0);
      check_val("t1_rdy_lat",  32'(src_rdy_o), 32'd1);
      check_val("t1_head",     32'({sof_o, dataout}), 32'h101);
      check_val("t1_pkt1",     32'(pkt_count), 32'd1);
      wait_drain();
      check_val("t1_pkt0", 32'(pkt_count), 32'd0);
      check_val("t1_occ0", 32'(occupied), 32'd0);

      // 2: 8-byte frame with error on eof
      drop0    = drop_cnt;
      seen_rdy = 1'b0;
      send_frame(8, 8'h10, 1'b1, 1'b0);
      idle(3);
      check_val("t2_dropped", 32'(drop_cnt - drop0), 32'd1);
      check_val("t2_occ0",    32'(occupied), 32'd0);
      check_val("t2_no_rdy",  32'(seen_rdy), 32'd0);

      // 3: oversize 20-byte frame then a 5-byte frame, consumer stalled
      dst_rdy_i = 1'b0;
      ovs0 = ovs_cnt;
      send_frame(20, 8'h20, 1'b0, 1'b0);
      check_val("t3_oversize", 32'(ovs_cnt - ovs0), 32'd1);
      check_val("t3_occ_ovs",  32'(occ_at_ovs), 32'd0);
      check_val("t3_occ_end",  32'(occupied), 32'd0);
      send_frame(5, 8'h50, 1'b0, 1'b1);
      check_val("t3_occ5", 32'(occupied), 32'd5);
      check_val("t3_pkt1", 32'(pkt_count), 32'd1);
      dst_rdy_i = 1'b1;
      wait_drain();

      // 4: three 5-byte frames plus a fourth into a stalled FIFO
      dst_rdy_i = 1'b0;
      ovs0 = ovs_cnt;
      send_frame(5, 8'hA0, 1'b0, 1'b1);
      send_frame(5, 8'hB0, 1'b0, 1'b1);
      send_frame(5, 8'hC0, 1'b0, 1'b1);
      check_val("t4_occ15", 32'(occupied), 32'd15);
      check_val("t4_pkt3",  32'(pkt_count), 32'd3);
      fork
         send_frame(5, 8'hD0, 1'b0, 1'b1);
         begin
            for (int n = 0; n < 50; n++) begin
               @(negedge clk);
               if (!dst_rdy_o) break;
            end
            check_val("t4_full_rdy", 32'(dst_rdy_o), 32'd0);
            check_val("t4_occ16",    32'(occupied), 32'd16);
            repeat (3) @(posedge clk);
            #1 dst_rdy_i = 1'b1;
         end
      join
      wait_drain();
      check_val("t4_pkt0",  32'(pkt_count), 32'd0);
      check_val("t4_no_ovs", 32'(ovs_cnt - ovs0), 32'd0);

      // 5: cut-through, error on the last byte passes through
      c_dst_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [DW-1:0] d;
         d = 8'h40 + DW'(i);
         c_datain = d; c_sof_i = (i == 0); c_eof_i = (i == 3); c_error_i = (i == 3);
         c_src_rdy_i = 1'b1;
         @(posedge clk);
         #1;
         check_val("t5_rdy",  32'(c_src_rdy_o), 32'd1);
         check_val("t5_word", 32'({c_error_o, c_sof_o, c_eof_o, c_dataout}),
                   32'({(i == 3), (i == 0), (i == 3), d}));
      end
      c_src_rdy_i = 1'b0;
      @(posedge clk);
      #1;
      check_val("t5_empty",   32'(c_src_rdy_o), 32'd0);
      idle(2);
      check_val("t5_no_drop", 32'(c_drop_cnt), 32'd0);

      // 6: reset mid-frame with one committed frame stored
      dst_rdy_i = 1'b0;
      send_frame(3, 8'h60, 1'b0, 1'b0);
      check_val("t6_pkt1", 32'(pkt_count), 32'd1);
      send_word(1'b1, 1'b0, 1'b0, 8'h70);
      send_word(1'b0, 1'b0, 1'b0, 8'h71);
      src_rdy_i = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_idle_outputs("t6_rst");
      @(posedge clk);
      #1 reset = 1'b1;
      dst_rdy_i = 1'b1;
      send_frame(3, 8'h80, 1'b0, 1'b1);
      wait_drain();
      check_val("t6_pkt0", 32'(pkt_count), 32'd0);

      // 7: synchronous clear drops a committed frame
      dst_rdy_i = 1'b0;
      send_frame(3, 8'h90, 1'b0, 1'b0);
      check_val("t7_pkt1", 32'(pkt_count), 32'd1);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      check_idle_outputs("t7_clr");
      idle(2);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
